// File: rtl/delay_sensor_reader.sv
// Capture side of the inverter-chain delay sensor: resynchronise the tap vector, decode the
// leading run of 1s and average it over 2^AVG_LOG2 samples. Define DELAY_SENSOR_READER_MINMAX_EN for min/max.
module delay_sensor_reader #(
  parameter int N_TAPS   = 8,
  parameter int AVG_LOG2 = 4,
  parameter int OUT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              continuous,
  input  logic [N_TAPS-1:0] taps,
  output logic [OUT_W-1:0]  result,
  output logic              result_valid,
  output logic              busy,
  output logic              bubble_err,
  output logic [OUT_W-1:0]  code_min,
  output logic [OUT_W-1:0]  code_max
);
  localparam int CW = $clog2(N_TAPS + 1);
  localparam int AW = CW + AVG_LOG2;

  typedef enum logic [1:0] {IDLE, FLUSH, ACCUM, DONE} state_t;
  state_t state, next_state;

  logic [N_TAPS-1:0]   taps_s1, taps_s2;
  logic [CW-1:0]       code;
  logic                bubble;
  logic                run_open;
  logic [AW-1:0]       acc;
  logic [AVG_LOG2-1:0] sample_cnt;
  logic                flush_cnt;
  logic                win_clear;
  logic                bubble_clear;
  logic                accum_en;
  logic                done_en;

  // Free-running two-flop synchroniser; taps are asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps_s1 <= '0;
      taps_s2 <= '0;
    end else begin
      taps_s1 <= taps;
      taps_s2 <= taps_s1;
    end
  end

  // Code is the run of 1s from bit 0; any 1 after the first 0 is a bubble.
  always_comb begin
    code     = '0;
    bubble   = 1'b0;
    run_open = 1'b1;
    for (int unsigned i = 0; i < N_TAPS; i++) begin
      if (run_open) begin
        if (taps_s2[i]) code = code + CW'(1);
        else            run_open = 1'b0;
      end else if (taps_s2[i]) begin
        bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state   = state;
    win_clear    = 1'b0;
    bubble_clear = 1'b0;
    accum_en     = 1'b0;
    done_en      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          next_state   = FLUSH;
          win_clear    = 1'b1;
          bubble_clear = 1'b1;
        end
      end
      FLUSH: begin
        if (flush_cnt) next_state = ACCUM;
      end
      ACCUM: begin
        accum_en = 1'b1;
        if (sample_cnt == '1) next_state = DONE;
      end
      DONE: begin
        done_en = 1'b1;
        if (continuous) begin
          next_state = ACCUM;
          win_clear  = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      sample_cnt   <= '0;
      flush_cnt    <= 1'b0;
      bubble_err   <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= done_en;
      flush_cnt    <= (state == FLUSH) ? ~flush_cnt : 1'b0;
      if (bubble_clear)            bubble_err <= 1'b0;
      else if (accum_en && bubble) bubble_err <= 1'b1;
      if (win_clear) begin
        acc        <= '0;
        sample_cnt <= '0;
      end else if (accum_en) begin
        acc        <= acc + AW'(code);
        sample_cnt <= sample_cnt + AVG_LOG2'(1);
      end
      if (done_en) result <= OUT_W'(acc[AW-1:AVG_LOG2]);
    end
  end

`ifdef DELAY_SENSOR_READER_MINMAX_EN
  logic [CW-1:0] win_min, win_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_min  <= '1;
      win_max  <= '0;
      code_min <= '0;
      code_max <= '0;
    end else begin
      if (win_clear) begin
        win_min <= '1;
        win_max <= '0;
      end else if (accum_en) begin
        if (code < win_min) win_min <= code;
        if (code > win_max) win_max <= code;
      end
      if (done_en) begin
        code_min <= OUT_W'(win_min);
        code_max <= OUT_W'(win_max);
      end
    end
  end
`else
  assign code_min = '0;
  assign code_max = '0;
`endif

endmodule

// File: tb/tb_delay_sensor_reader.sv
// Scoreboard bench for delay_sensor_reader: the driver pushes per-window expectations computed
// from the tap stream; a negedge monitor pops one on every result_valid.
module tb_delay_sensor_reader;
  localparam int N_TAPS   = 8;
  localparam int AVG_LOG2 = 4;
  localparam int OUT_W    = 8;
  localparam int WIN      = 1 << AVG_LOG2;
  localparam int PERIOD   = WIN + 1;
  localparam int LAT      = WIN + 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             continuous = 1'b0;
  logic [N_TAPS-1:0] taps = '0;
  logic [OUT_W-1:0] result, code_min, code_max;
  logic             result_valid, busy, bubble_err;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int res;
    int mn;
    int mx;
    bit bub;
    int at;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  delay_sensor_reader #(
    .N_TAPS  (N_TAPS),
    .AVG_LOG2(AVG_LOG2),
    .OUT_W   (OUT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .continuous  (continuous),
    .taps        (taps),
    .result      (result),
    .result_valid(result_valid),
    .busy        (busy),
    .bubble_err  (bubble_err),
    .code_min    (code_min),
    .code_max    (code_max)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: code is the count of consecutive 1s from bit 0.
  function automatic int decode_code(input logic [7:0] t);
    int n = 0;
    while (n < 8 && t[n]) n++;
    return n;
  endfunction

  function automatic bit is_bubble(input logic [7:0] t);
    logic [8:0] thermo;
    thermo = (9'd1 << decode_code(t)) - 9'd1;
    return {1'b0, t} != thermo;
  endfunction

  function automatic logic [7:0] gen_tap(input int mode, input int t, input logic [7:0] a,
                                         input logic [7:0] b);
    logic [8:0] th;
    case (mode)
      0: return a;
      1: return (t % 2 == 0) ? a : b;
      default: begin
        if ($urandom_range(0, 9) < 7) begin
          th = (9'd1 << $urandom_range(0, 8)) - 9'd1;
          return th[7:0];
        end
        return 8'($urandom);
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && result_valid) begin
      if (sb.size() == 0) begin
        check("spurious_result_valid", int'(result_valid), 0);
      end else begin
        mon_e = sb.pop_front();
        check("result_time", cyc, mon_e.at);
        check("result", int'(result), mon_e.res);
        check("code_min", int'(code_min), mon_e.mn);
        check("code_max", int'(code_max), mon_e.mx);
        check("bubble_err", int'(bubble_err), int'(mon_e.bub));
      end
    end
  end

  // Entered just after a rising edge with the DUT idle. Slot t of the stream is present at
  // edge k+1+t; window w uses slots w*PERIOD .. w*PERIOD+WIN-1, the remaining slot is ignored.
  task automatic measure(input int nwin, input int mode, input logic [7:0] a,
                         input logic [7:0] b, input bit extra_starts);
    logic [7:0] stream[$];
    int   k, sum, mn, mx, c;
    bit   bub;
    exp_t e;
    int   nslot;
    nslot = PERIOD * nwin;
    for (int t = 0; t < nslot; t++) stream.push_back(gen_tap(mode, t, a, b));
    k   = cyc + 1;
    bub = 1'b0;
    for (int w = 0; w < nwin; w++) begin
      sum = 0;
      mn  = 255;
      mx  = 0;
      for (int i = 0; i < WIN; i++) begin
        c   = decode_code(stream[w*PERIOD+i]);
        sum += c;
        if (c < mn) mn = c;
        if (c > mx) mx = c;
        bub |= is_bubble(stream[w*PERIOD+i]);
      end
      e.res = sum / WIN;
`ifdef DELAY_SENSOR_READER_MINMAX_EN
      e.mn = mn;
      e.mx = mx;
`else
      e.mn = 0;
      e.mx = 0;
`endif
      e.bub = bub;
      e.at  = k + LAT + w * PERIOD;
      sb.push_back(e);
    end
    start      = 1'b1;
    continuous = (nwin > 1);
    @(posedge clk); #1;
    start = 1'b0;
    check("bubble_clear_on_start", int'(bubble_err), 0);
    for (int t = 0; t < nslot; t++) begin
      taps = stream[t];
      if (extra_starts) start = (t == 0 || t == 8);
      if (nwin > 1 && t == PERIOD * (nwin - 1) + 5) continuous = 1'b0;
      check("busy_in_window", int'(busy), 1);
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("busy_after_done", int'(busy), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_result"}, int'(result), 0);
    check({tag, "_result_valid"}, int'(result_valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_bubble_err"}, int'(bubble_err), 0);
    check({tag, "_code_min"}, int'(code_min), 0);
    check({tag, "_code_max"}, int'(code_max), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("por");
    rst_n = 1'b1;
    @(posedge clk); #1;

    measure(1, 0, 8'h0F, 8'h00, 1'b0);
    measure(1, 0, 8'h17, 8'h00, 1'b0);
    measure(1, 0, 8'h0F, 8'h00, 1'b0);
    measure(1, 1, 8'h03, 8'h3F, 1'b0);
    measure(3, 0, 8'hFF, 8'h00, 1'b0);
    measure(1, 0, 8'h0F, 8'h00, 1'b1);

    // Abort mid-window: reset lands before the sixth accumulated sample.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    taps  = 8'h17;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check_reset_values("abort");
    measure(1, 0, 8'h0F, 8'h00, 1'b0);

    for (int r = 0; r < 6; r++)
      measure(int'($urandom_range(1, 3)), 2, 8'h00, 8'h00, 1'($urandom_range(0, 1)));

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/delay_sensor_reader.md
# delay_sensor_reader

Capture-side companion to the inverter-chain delay sensor. Samples the sensor's thermometer-coded tap vector on every `clk` edge, resynchronises it, and decodes it to a delay code (number of stages the launched edge travelled within one clock cycle). Averages the code over a window of 2^AVG_LOG2 samples and presents a registered result, optional min/max, and a sticky bubble-error flag. Sits between the sensor taps and the tile's `uo_out` mux.

## Interface
- `N_TAPS`, 8, number of delay-line taps presented on `taps`
- `AVG_LOG2`, 4, log2 of samples per averaging window (1..8)
- `OUT_W`, 8, width of `result`, `code_min`, `code_max`; must be ≥ CW = clog2(N_TAPS+1)

- `clk`  in  1  system clock, the same clock that launches the sensor chain
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  single-cycle request to begin a measurement; honoured only in IDLE
- `continuous`  in  1  when 1, start a new window immediately after each result
- `taps`  in  N_TAPS  raw delay-line taps; bit 0 is nearest the chain input; asynchronous to `clk`
- `result`  out  OUT_W  window average, zero-extended
- `result_valid`  out  1  one-cycle pulse when `result` updates
- `busy`  out  1  high in every state except IDLE
- `bubble_err`  out  1  sticky; set on any non-thermometer sample
- `code_min`  out  OUT_W  smallest code in the last window
- `code_max`  out  OUT_W  largest code in the last window

## Operation
- Resynchronisation: two-flop synchroniser on all `taps` bits, free-running, not reset-gated beyond rst_n (both stages reset to 0).
- Decode: code = length of the run of 1s starting at bit 0 (0..N_TAPS). Bubble = any 1 above the first 0; set `bubble_err`. The code still uses the leading run.
- FSM states: IDLE, FLUSH, ACCUM, DONE.
  - IDLE: `start`=1 → FLUSH; clear `bubble_err`, accumulator, sample counter, window min/max.
  - FLUSH: exactly 2 cycles (synchroniser refill) → ACCUM.
  - ACCUM: adds one decoded code per cycle for 2^AVG_LOG2 cycles. Accumulator width CW+AVG_LOG2, no overflow possible. Tracks running min (init all-ones) and max (init 0). → DONE.
  - DONE: 1 cycle. Registers `result` = accumulator >> AVG_LOG2 (truncating), `code_min`, `code_max`; pulses `result_valid`. If `continuous`=1 → ACCUM with accumulator, counter and min/max cleared, `bubble_err` held. Otherwise → IDLE.
- `start` in any state other than IDLE is ignored. Clearing `continuous` takes effect at the next DONE.
- `result`, `code_min`, `code_max` hold their value until the next DONE.
- Reset, including mid-window: all state returns to IDLE immediately. The partial window is discarded.

## Timing
- Reset values: `result`=0, `result_valid`=0, `busy`=0, `bubble_err`=0, `code_min`=0, `code_max`=0, FSM=IDLE.
- `start` sampled high at edge k: `busy`=1 from k+1. FLUSH covers k+1..k+2. ACCUM covers k+3..k+2+2^AVG_LOG2. DONE and the `result_valid` pulse occur at k+3+2^AVG_LOG2. With defaults that is 19 cycles.
- Sample dependency: tap values present at edge j affect the code accumulated at edge j+2.
- Continuous mode: `result_valid` period is 2^AVG_LOG2+1 cycles (17 with defaults). `busy` stays high.
- Non-continuous: `busy` falls the cycle after DONE. A `start` in that same cycle (IDLE) is accepted.
- `bubble_err` rises 2 cycles after the offending tap pattern, provided the decode falls within ACCUM.

## Configuration
- `DELAY_SENSOR_READER_MINMAX_EN`
  - Defined: min/max trackers are built; `code_min`/`code_max` are driven as described above.
  - Undefined: no tracker logic; `code_min`/`code_max` are tied to 0. Ports remain present.

## Test plan
- Constant taps 8'b00001111, defaults, pulse `start` → `result_valid` 19 cycles later, `result`=4, `code_min`=`code_max`=4, `bubble_err`=0.
- Taps 8'b00010111 held → `result`=3, `bubble_err`=1. A later `start` with clean taps clears `bubble_err`.
- Taps alternating each cycle between 8'b00000011 and 8'b00111111 → `result`=4, `code_min`=2, `code_max`=6 (MINMAX_EN defined; both 0 when undefined).
- `continuous`=1, taps 8'hFF → `result`=8, `result_valid` every 17 cycles, `busy` never drops. Clear `continuous` → exactly one more result, then IDLE.
- Assert `rst_n`=0 for 1 cycle at ACCUM sample 5 → all outputs at reset values. Re-`start` → full 19-cycle latency.
- `start` pulsed during FLUSH and ACCUM → ignored: a single `result_valid` at the original time.
